// File: rtl/block_spawner_if.sv
// block_spawner_if: frame strobe and run gate in, packed obstacle slot buses out.
interface block_spawner_if;
    logic        update_screen;
    logic        enable;
    logic [54:0] load_block_bottom_left_corner_x_pos;
    logic [54:0] load_block_bottom_left_corner_y_pos;
    logic [10:0] load_curr_shape_id;
    logic [10:0] scroll;
    logic        spawn_pulse;
    logic        ready;
    modport master (
        input  update_screen, enable,
        output load_block_bottom_left_corner_x_pos, load_block_bottom_left_corner_y_pos,
               load_curr_shape_id, scroll, spawn_pulse, ready
    );
    modport slave (
        output update_screen, enable,
        input  load_block_bottom_left_corner_x_pos, load_block_bottom_left_corner_y_pos,
               load_curr_shape_id, scroll, spawn_pulse, ready
    );
endinterface

// File: rtl/block_spawner.sv
// block_spawner: five-slot obstacle source with LFSR spacing/height and scroll-synchronous recycling.
module block_spawner #(
    parameter logic [10:0] START_X     = 11'd160,
    parameter logic [10:0] GROUND_Y    = 11'd89,
    parameter logic [10:0] BLOCK_H     = 11'd10,
    parameter logic [10:0] BLOCK_W     = 11'd10,
    parameter logic [10:0] GAP_MIN     = 11'd40,
    parameter logic [10:0] SCROLL_STEP = 11'd2,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic clock,
    input logic reset,
    block_spawner_if.master bus
);
    typedef enum logic {FILL, RUN} state_t;
    state_t      state;
    logic [2:0]  fill_idx;
    logic [10:0] x_q [5];
    logic [10:0] y_q [5];
    logic [4:0]  tall;
    logic [15:0] lfsr;
    logic [10:0] tail_x;
    logic [10:0] scroll_q;
    logic        spawn_q;
    logic        ready_q;
    logic [10:0] gap;
    logic [10:0] new_y;
    logic [10:0] write_x;
    logic [15:0] lfsr_nxt;
    logic [4:0]  expired;
    logic [2:0]  victim;
    assign gap      = GAP_MIN + {5'd0, lfsr[4:0], 1'b0};
    assign new_y    = lfsr[5] ? GROUND_Y - BLOCK_H : GROUND_Y;
    assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign write_x  = (state == FILL && fill_idx == 3'd0) ? START_X : tail_x + gap;
    genvar g;
    for (g = 0; g < 5; g++) begin : g_slot
        logic [10:0] rel;
        // Sign bit of the 11-bit distance from the left edge; valid while live spread < 1024.
        assign rel        = x_q[g] + BLOCK_W - scroll_q;
        assign expired[g] = rel[10];
        assign bus.load_block_bottom_left_corner_x_pos[11*g +: 11] = x_q[g];
        assign bus.load_block_bottom_left_corner_y_pos[11*g +: 11] = y_q[g];
    end
    assign victim = expired[0] ? 3'd0 : expired[1] ? 3'd1 : expired[2] ? 3'd2 : expired[3] ? 3'd3 : 3'd4;
    assign bus.load_curr_shape_id = {6'd0, tall};
    assign bus.scroll             = scroll_q;
    assign bus.spawn_pulse        = spawn_q;
    assign bus.ready              = ready_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= FILL;
            fill_idx <= 3'd0;
            for (int i = 0; i < 5; i++) begin
                x_q[i] <= 11'd0;
                y_q[i] <= GROUND_Y;
            end
            tall     <= 5'd0;
            lfsr     <= LFSR_SEED;
            tail_x   <= 11'd0;
            scroll_q <= 11'd0;
            spawn_q  <= 1'b0;
            ready_q  <= 1'b0;
        end else if (state == FILL) begin
            x_q[fill_idx]  <= write_x;
            y_q[fill_idx]  <= new_y;
            tall[fill_idx] <= lfsr[5];
            tail_x         <= write_x;
            lfsr           <= lfsr_nxt;
            fill_idx       <= fill_idx + 3'd1;
            spawn_q        <= 1'b0;
            ready_q        <= 1'b0;
            if (fill_idx == 3'd4)
                state <= RUN;
        end else begin
            ready_q <= 1'b1;
            spawn_q <= 1'b0;
            if (bus.update_screen && bus.enable) begin
                scroll_q <= scroll_q + SCROLL_STEP;
                if (|expired) begin
                    x_q[victim]  <= write_x;
                    y_q[victim]  <= new_y;
                    tall[victim] <= lfsr[5];
                    tail_x       <= write_x;
                    lfsr         <= lfsr_nxt;
                    spawn_q      <= 1'b1;
                end
            end
        end
    end
endmodule
